// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the parametrised ID/WB register file.
// Holds the default sizes plus the address-width and port-slice helpers.
package regfile_pkg;

  localparam int          DEF_WIDTH       = 32;
  localparam int          DEF_DEPTH       = 32;
  localparam logic [31:0] DEF_RESET_VALUE = 32'hFFFF_FFFF;

  // Ceiling log2, kept local so sizes can be derived in parameter lists.
  function automatic int calc_aw(input int depth);
    int aw;
    aw = 0;
    while ((1 << aw) < depth) aw++;
    return aw;
  endfunction

  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: zero-register masking, write-first bypass and
// the scoreboard stall for a single operand address.
module rf_read_port #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic [DEPTH*WIDTH-1:0] regs_i,
  input  logic [DEPTH-1:0]       busy_i,
  input  logic                   wr_en_i,
  input  logic [AW-1:0]          wr_addr_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic [AW-1:0]          addr_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   stall_o
);

  logic isZero;
  logic wrHit;

  assign isZero = ZERO_REG && (addr_i == '0);
  assign wrHit  = wr_en_i && (wr_addr_i == addr_i);

  // A writeback landing this cycle both supplies the data and clears the hazard.
  always_comb begin
    data_o = regs_i[int'(addr_i)*WIDTH +: WIDTH];
    if (isZero)
      data_o = '0;
    else if (wrHit)
      data_o = wr_data_i;
    stall_o = busy_i[addr_i] && !wrHit && !isZero;
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with write-first bypass and a per-register busy scoreboard
// for the ID (issue/read) and WB (writeback) stages of the 5-stage core.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int          WIDTH       = DEF_WIDTH,
  parameter int          DEPTH       = DEF_DEPTH,
  parameter int          NUM_RD      = 2,
  parameter logic [31:0] RESET_VALUE = DEF_RESET_VALUE,
  parameter bit          ZERO_REG    = 1'b1,
  localparam int         AW          = calc_aw(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]       rd_stall,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    iss_en,
  input  logic [AW-1:0]           iss_addr,
  input  logic                    flush,
  input  logic [AW-1:0]           dbg_addr,
  output logic [WIDTH-1:0]        dbg_data,
  output logic [DEPTH-1:0]        busy_vec
);

  localparam logic [WIDTH-1:0] RV = WIDTH'(RESET_VALUE);

  logic [DEPTH*WIDTH-1:0] regs_q, regs_d;
  logic [DEPTH-1:0]       busy_q, busy_d;

  always_comb begin
    regs_d = regs_q;
    if (wr_en && !(ZERO_REG && wr_addr == '0))
      regs_d[int'(wr_addr)*WIDTH +: WIDTH] = wr_data;
  end

  // Flush squashes everything first; the issuing instruction survives, and a
  // same-register issue beats the writeback because a newer producer is in flight.
  always_comb begin
    busy_d = busy_q;
    if (flush)
      busy_d = '0;
    if (wr_en)
      busy_d[wr_addr] = 1'b0;
    if (iss_en && !(ZERO_REG && iss_addr == '0))
      busy_d[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= {DEPTH{RV}};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  always_comb begin
    dbg_data = regs_q[int'(dbg_addr)*WIDTH +: WIDTH];
    if (ZERO_REG && dbg_addr == '0)
      dbg_data = '0;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    rf_read_port #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .AW      (AW),
      .ZERO_REG(ZERO_REG)
    ) u_port (
      .regs_i   (regs_q),
      .busy_i   (busy_q),
      .wr_en_i  (wr_en),
      .wr_addr_i(wr_addr),
      .wr_data_i(wr_data),
      .addr_i   (rd_addr[slice_lo(k, AW) +: AW]),
      .data_o   (rd_data[slice_lo(k, WIDTH) +: WIDTH]),
      .stall_o  (rd_stall[k])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: a default 32x32/2-port instance and a
// 16-bit, 8-deep, 3-port instance without a hard-wired zero register.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Default instance: WIDTH 32, DEPTH 32, AW 5, NUM_RD 2, ZERO_REG 1
  logic [9:0]  aRdAddr = '0;
  logic [63:0] aRdData;
  logic [1:0]  aRdStall;
  logic        aWrEn = 1'b0;
  logic [4:0]  aWrAddr = '0;
  logic [31:0] aWrData = '0;
  logic        aIssEn = 1'b0;
  logic [4:0]  aIssAddr = '0;
  logic        aFlush = 1'b0;
  logic [4:0]  aDbgAddr = '0;
  logic [31:0] aDbgData;
  logic [31:0] aBusy;

  // Swept instance: WIDTH 16, DEPTH 8, AW 3, NUM_RD 3, ZERO_REG 0
  logic [8:0]  bRdAddr = '0;
  logic [47:0] bRdData;
  logic [2:0]  bRdStall;
  logic        bWrEn = 1'b0;
  logic [2:0]  bWrAddr = '0;
  logic [15:0] bWrData = '0;
  logic        bIssEn = 1'b0;
  logic [2:0]  bIssAddr = '0;
  logic [2:0]  bDbgAddr = '0;
  logic [15:0] bDbgData;
  logic [7:0]  bBusy;

  int vectorCount = 0;
  int missCount   = 0;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;
  exp_t expQ[$];

  always #5 clk = ~clk;

  regfile_sb dutA (
    .clk(clk), .rst(rst),
    .rd_addr(aRdAddr), .rd_data(aRdData), .rd_stall(aRdStall),
    .wr_en(aWrEn), .wr_addr(aWrAddr), .wr_data(aWrData),
    .iss_en(aIssEn), .iss_addr(aIssAddr), .flush(aFlush),
    .dbg_addr(aDbgAddr), .dbg_data(aDbgData), .busy_vec(aBusy)
  );

  regfile_sb #(.WIDTH(16), .DEPTH(8), .NUM_RD(3), .ZERO_REG(1'b0)) dutB (
    .clk(clk), .rst(rst),
    .rd_addr(bRdAddr), .rd_data(bRdData), .rd_stall(bRdStall),
    .wr_en(bWrEn), .wr_addr(bWrAddr), .wr_data(bWrData),
    .iss_en(bIssEn), .iss_addr(bIssAddr), .flush(1'b0),
    .dbg_addr(bDbgAddr), .dbg_data(bDbgData), .busy_vec(bBusy)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectorCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic pushExpected(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    expQ.push_back(e);
  endtask

  task automatic checkNext(input logic [63:0] obs);
    exp_t e;
    if (expQ.size() == 0)
      checkOutput("sb-underflow", obs, 64'hx);
    else begin
      e = expQ.pop_front();
      checkOutput(e.tag, obs, e.val);
    end
  endtask

  task automatic applyStimulus(input logic wrEn, input logic [4:0] wrAddr, input logic [31:0] wrData,
                               input logic issEn, input logic [4:0] issAddr, input logic flush);
    aWrEn    = wrEn;
    aWrAddr  = wrAddr;
    aWrData  = wrData;
    aIssEn   = issEn;
    aIssAddr = issAddr;
    aFlush   = flush;
  endtask

  task automatic idleA();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset, then a real busy bit so the async reset has something to clear
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 1'b0);
    pushExpected("busy-after-issue2", 64'h4);
    tick();
    checkNext(64'(aBusy));
    idleA();

    @(negedge clk);
    #2;
    applyStimulus(1'b1, 5'd5, 32'h1111_1111, 1'b1, 5'd9, 1'b0);
    rst = 1'b1;
    pushExpected("async-reset-busy", 64'h0);
    #1;
    checkNext(64'(aBusy));
    tick();
    idleA();
    aRdAddr = {5'd0, 5'd5};
    pushExpected("reset-rd-data", {32'h0, 32'hFFFF_FFFF});
    pushExpected("reset-rd-stall", 64'h0);
    pushExpected("reset-busy-kept", 64'h0);
    #1;
    checkNext(aRdData);
    checkNext(64'(aRdStall));
    checkNext(64'(aBusy));
    @(negedge clk);
    rst = 1'b0;

    // Write then read, and register 0 ignores writes
    applyStimulus(1'b1, 5'd7, 32'h1234_5678, 1'b0, 5'd0, 1'b0);
    tick();
    idleA();
    aRdAddr = {5'd7, 5'd7};
    pushExpected("wr7-both-ports", {32'h1234_5678, 32'h1234_5678});
    pushExpected("wr7-stall", 64'h0);
    #1;
    checkNext(aRdData);
    checkNext(64'(aRdStall));

    @(negedge clk);
    applyStimulus(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0);
    aRdAddr = {5'd5, 5'd0};
    pushExpected("reg0-no-bypass", {32'hFFFF_FFFF, 32'h0});
    #1;
    checkNext(aRdData);
    tick();
    idleA();
    pushExpected("reg0-after-write", {32'hFFFF_FFFF, 32'h0});
    #1;
    checkNext(aRdData);

    // Bypass: read port sees the write before the edge, debug port does not
    @(negedge clk);
    applyStimulus(1'b1, 5'd9, 32'hA5A5_A5A5, 1'b0, 5'd0, 1'b0);
    aRdAddr  = {5'd7, 5'd9};
    aDbgAddr = 5'd9;
    pushExpected("bypass-rd9", {32'h1234_5678, 32'hA5A5_A5A5});
    pushExpected("dbg9-before-edge", 64'hFFFF_FFFF);
    #1;
    checkNext(aRdData);
    checkNext(64'(aDbgData));
    tick();
    idleA();
    pushExpected("dbg9-after-edge", 64'hA5A5_A5A5);
    #1;
    checkNext(64'(aDbgData));

    // Scoreboard: issue to 3, stall, then the writeback satisfies it
    @(negedge clk);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0);
    aRdAddr = {5'd3, 5'd7};
    tick();
    idleA();
    pushExpected("busy3-set", 64'h8);
    pushExpected("stall-port1-on-3", 64'h2);
    #1;
    checkNext(64'(aBusy));
    checkNext(64'(aRdStall));
    @(negedge clk);
    applyStimulus(1'b1, 5'd3, 32'hCAFE_0003, 1'b0, 5'd0, 1'b0);
    pushExpected("wb3-stall-clear", 64'h0);
    pushExpected("wb3-bypass-data", {32'hCAFE_0003, 32'h1234_5678});
    #1;
    checkNext(64'(aRdStall));
    checkNext(aRdData);
    tick();
    idleA();
    pushExpected("busy3-cleared", 64'h0);
    #1;
    checkNext(64'(aBusy));

    // Same-cycle issue and writeback to 4: data commits, set wins
    @(negedge clk);
    applyStimulus(1'b1, 5'd4, 32'h4444_4444, 1'b1, 5'd4, 1'b0);
    tick();
    idleA();
    aRdAddr = {5'd3, 5'd4};
    pushExpected("iss-wr-4-busy", 64'h10);
    pushExpected("iss-wr-4-data", {32'hCAFE_0003, 32'h4444_4444});
    pushExpected("iss-wr-4-stall", 64'h1);
    #1;
    checkNext(64'(aBusy));
    checkNext(aRdData);
    checkNext(64'(aRdStall));

    @(negedge clk);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 1'b0);
    tick();
    pushExpected("busy-0x110", 64'h110);
    #1;
    checkNext(64'(aBusy));

    // Flush keeps only the issuing instruction; the writeback still commits
    @(negedge clk);
    applyStimulus(1'b1, 5'd10, 32'h0000_00AA, 1'b1, 5'd6, 1'b1);
    tick();
    idleA();
    aRdAddr = {5'd10, 5'd6};
    pushExpected("flush-survivor", 64'h40);
    pushExpected("flush-wb-commit", {32'h0000_00AA, 32'hFFFF_FFFF});
    pushExpected("flush-stall", 64'h1);
    #1;
    checkNext(64'(aBusy));
    checkNext(aRdData);
    checkNext(64'(aRdStall));

    // WAW re-issue keeps 6 busy, issue to reg 0 is ignored
    @(negedge clk);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b0);
    tick();
    idleA();
    pushExpected("waw-and-zero-issue", 64'h40);
    #1;
    checkNext(64'(aBusy));

    // Swept instance: reset value truncation, reg 0 writable and scoreboarded
    @(negedge clk);
    bRdAddr = {3'd2, 3'd1, 3'd0};
    pushExpected("b-reset-data", {16'h0, 16'hFFFF, 16'hFFFF, 16'hFFFF});
    #1;
    checkNext(64'(bRdData));
    bWrEn = 1'b1; bWrAddr = 3'd0; bWrData = 16'h1234;
    tick();
    @(negedge clk);
    bWrAddr = 3'd5; bWrData = 16'h5555;
    tick();
    bWrEn = 1'b0;
    bRdAddr = {3'd7, 3'd5, 3'd0};
    pushExpected("b-three-ports", {16'h0, 16'hFFFF, 16'h5555, 16'h1234});
    #1;
    checkNext(64'(bRdData));
    @(negedge clk);
    bIssEn = 1'b1; bIssAddr = 3'd0;
    tick();
    bIssEn = 1'b0;
    pushExpected("b-busy0", 64'h1);
    pushExpected("b-stall0", 64'h1);
    #1;
    checkNext(64'(bBusy));
    checkNext(64'(bRdStall));

    checkOutput("sb-drain", 64'(expQ.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
